// File: rtl/clock_meter_pkg.sv
// Shared constants for the clock period meter: FSM encoding and parameter defaults.
package clock_meter_pkg;

    localparam int          CNT_W_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 32'd65535;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into the clock_in domain and flags its rising edges.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic signal_in,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    // Synchronizer chain followed by one delay flop for edge detection.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow square wave in clock_in cycles and
// presents each result through a single-entry valid/ready hold register.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             signal_in,
    input  logic             enable,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             overrun,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             sync_s;
    logic             rise_s;
    logic             capture_s;
    logic             transfer_s;

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] hcnt_q,   hcnt_d;
    logic             tmo_q,    tmo_d;
    logic             valid_q,  valid_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q,   high_d;
    logic             ovr_q,    ovr_d;
    logic             pend_q,   pend_d;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .signal_in (signal_in),
        .sync_o    (sync_s),
        .rise_o    (rise_s)
    );

    // FSM and counters; enable low overrides everything and discards the measurement.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        tmo_d     = 1'b0;
        capture_s = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise_s) begin
                        state_d = ST_MEAS;
                        cnt_d   = CNT_ONE;
                        hcnt_d  = CNT_ONE;
                    end else begin
                        state_d = ST_ARM;
                    end
                end
                ST_MEAS: begin
                    if (rise_s) begin
                        capture_s = 1'b1;
                        cnt_d     = CNT_ONE;
                        hcnt_d    = CNT_ONE;
                    end else if (cnt_q == TIMEOUT_C) begin
                        tmo_d   = 1'b1;
                        state_d = ST_ARM;
                    end else begin
                        cnt_d  = cnt_q + CNT_ONE;
                        hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, sync_s};
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign transfer_s = valid_q & meas_ready;

    // Hold register: a capture while the consumer stalls is dropped and remembered in pend.
    always_comb begin
        valid_d  = valid_q;
        period_d = period_q;
        high_d   = high_q;
        ovr_d    = ovr_q;
        pend_d   = pend_q;
        if (capture_s) begin
            if (valid_q && !meas_ready) begin
                pend_d = 1'b1;
            end else begin
                valid_d  = 1'b1;
                period_d = cnt_q;
                high_d   = hcnt_q;
                ovr_d    = pend_q;
                pend_d   = 1'b0;
            end
        end else if (transfer_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            hcnt_q   <= {CNT_W{1'b0}};
            tmo_q    <= 1'b0;
            valid_q  <= 1'b0;
            period_q <= {CNT_W{1'b0}};
            high_q   <= {CNT_W{1'b0}};
            ovr_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            tmo_q    <= tmo_d;
            valid_q  <= valid_d;
            period_q <= period_d;
            high_q   <= high_d;
            ovr_q    <= ovr_d;
            pend_q   <= pend_d;
        end
    end

    assign meas_valid = valid_q;
    assign period     = period_q;
    assign high_time  = high_q;
    assign overrun    = ovr_q;
    assign timeout    = tmo_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench: divider-driven vector table plus hand-written corner sequences,
// with results checked through an expected-result queue at every transfer.
module tb_clock_period_meter;

    localparam int CW = 16;
    localparam int SS = 2;
    localparam int TO = 50;

    typedef struct {
        int div;
        int per;
        int hi;
        int n;
    } vec_t;

    typedef struct {
        int per;
        int hi;
        int ovr;
    } exp_t;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          enable     = 1'b0;
    logic          meas_ready = 1'b0;
    logic          sig_mode   = 1'b0;
    logic          sig_man    = 1'b0;
    logic          div_out    = 1'b0;
    logic          sig_in;
    logic          meas_valid;
    logic          overrun;
    logic          timeout;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;

    int   div        = 4;
    int   div_cnt    = 0;
    int   total      = 0;
    int   bad        = 0;
    int   xfer_cnt   = 0;
    bit   allow_extra = 1'b0;
    exp_t sb[$];

    clock_period_meter #(
        .CNT_W       (CW),
        .SYNC_STAGES (SS),
        .TIMEOUT     (TO)
    ) dut (
        .clock_in   (clk),
        .reset_n    (rst_n),
        .signal_in  (sig_in),
        .enable     (enable),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .period     (period),
        .high_time  (high_time),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Reference clock divider: high for div/2 cycles of every div.
    always @(posedge clk) begin
        if (div_cnt >= div - 1) div_cnt <= 0;
        else                    div_cnt <= div_cnt + 1;
        div_out <= (div_cnt < div / 2);
    end

    assign sig_in = sig_mode ? sig_man : div_out;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && meas_valid && meas_ready) begin
            exp_t e;
            xfer_cnt++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_period", int'(period), e.per);
                chk("sb_high_time", int'(high_time), e.hi);
                chk("sb_overrun", int'(overrun), e.ovr);
            end else if (!allow_extra) begin
                chk("unexpected_result", 1, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int per, input int hi, input int ovr, input int n);
        exp_t e;
        e.per = per;
        e.hi  = hi;
        e.ovr = ovr;
        repeat (n) sb.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (sb.size() > 0 && k < budget) begin
            tick(1);
            k++;
        end
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        while (!meas_valid && k < budget) begin
            tick(1);
            k++;
        end
        chk(name, int'(meas_valid), 1);
    endtask

    task automatic stop_and_flush();
        allow_extra = 1'b1;
        enable      = 1'b0;
        tick(12);
        allow_extra = 1'b0;
    endtask

    task automatic man_period(input int w, input int p);
        sig_man = 1'b1;
        tick(w);
        sig_man = 1'b0;
        tick(p - w);
    endtask

    initial begin
        vec_t vecs[5];
        int   tmo_at;
        int   vseen;
        int   stable;
        vecs[0] = '{div: 4, per: 4, hi: 2, n: 4};
        vecs[1] = '{div: 5, per: 5, hi: 2, n: 3};
        vecs[2] = '{div: 2, per: 2, hi: 1, n: 5};
        vecs[3] = '{div: 3, per: 3, hi: 1, n: 3};
        vecs[4] = '{div: 6, per: 6, hi: 3, n: 3};

        #1 rst_n = 1'b0;
        tick(3);
        chk("reset_valid", int'(meas_valid), 0);
        chk("reset_period", int'(period), 0);
        chk("reset_high", int'(high_time), 0);
        chk("reset_overrun", int'(overrun), 0);
        chk("reset_timeout", int'(timeout), 0);
        rst_n = 1'b1;
        meas_ready = 1'b1;
        tick(2);

        for (int i = 0; i < 5; i++) begin
            div = vecs[i].div;
            tick(2 * vecs[i].div + 2);
            push_exp(vecs[i].per, vecs[i].hi, 0, vecs[i].n);
            enable = 1'b1;
            wait_drain($sformatf("drain_div%0d", vecs[i].div), 200);
            stop_and_flush();
        end

        // Backpressure: first result held, later ones dropped and flagged.
        div = 4;
        meas_ready = 1'b0;
        tick(10);
        push_exp(4, 2, 0, 1);
        push_exp(4, 2, 1, 1);
        push_exp(4, 2, 0, 1);
        enable = 1'b1;
        wait_valid("bp_first_valid", 60);
        stable = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (meas_valid && period == 16'd4 && high_time == 16'd2 && !overrun) stable++;
        end
        chk("bp_hold_stable_cycles", stable, 20);
        tick(1);
        meas_ready = 1'b1;
        wait_drain("bp_drain", 60);
        stop_and_flush();

        // Timeout: one rise enters MEAS, then the line stays low.
        sig_mode = 1'b1;
        sig_man  = 1'b0;
        enable   = 1'b1;
        tick(4);
        sig_man = 1'b1;
        tmo_at  = 0;
        vseen   = 0;
        for (int n = 1; n <= 120 && tmo_at == 0; n++) begin
            @(posedge clk);
            if (n == 3) begin
                #1 sig_man = 1'b0;
            end
            @(negedge clk);
            if (meas_valid) vseen = 1;
            if (timeout) tmo_at = n;
        end
        chk("timeout_latency", tmo_at, TO + SS + 1);
        chk("timeout_no_valid", vseen, 0);
        @(negedge clk);
        chk("timeout_one_cycle", int'(timeout), 0);
        tick(1);
        push_exp(10, 3, 0, 1);
        man_period(3, 10);
        man_period(3, 10);
        wait_drain("after_timeout_rearm", 40);
        stop_and_flush();

        // enable dropped mid-measurement: that period is lost, two rises needed again.
        xfer_cnt = 0;
        enable   = 1'b1;
        tick(4);
        push_exp(8, 2, 0, 3);
        man_period(2, 8);
        man_period(2, 8);
        sig_man = 1'b1;
        tick(2);
        sig_man = 1'b0;
        tick(2);
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(2);
        chk("xfers_before_disable", xfer_cnt, 2);
        man_period(2, 8);
        chk("no_result_first_rise_after_reenable", xfer_cnt, 2);
        man_period(2, 8);
        wait_drain("reenable_drain", 20);
        chk("xfers_after_reenable", xfer_cnt, 3);
        stop_and_flush();

        // Asynchronous reset in MEAS with a pending result.
        sig_mode   = 1'b0;
        div        = 4;
        meas_ready = 1'b0;
        tick(8);
        enable = 1'b1;
        wait_valid("rst_pending_valid", 60);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(meas_valid), 0);
        chk("async_rst_period", int'(period), 0);
        chk("async_rst_high", int'(high_time), 0);
        chk("async_rst_overrun", int'(overrun), 0);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_valid", int'(meas_valid), 0);
        meas_ready = 1'b1;
        push_exp(4, 2, 0, 2);
        wait_drain("post_rst_drain", 60);
        stop_and_flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
